// File: rtl/rom128x32_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom128x32_arbiter
//  Purpose  : Shares one 128x32 single-port synchronous ROM macro between two
//             read requesters. Round-robin arbitration, ROM CEB/A generation
//             and a held response register with per-port valid/ready.
//  Ports    : clk, resetn             clock, synchronous active-low reset
//             Req0/Addr0/Gnt0         port 0 request, address, grant
//             RspValid0/RspReady0     port 0 response handshake
//             Req1/Addr1/Gnt1         port 1 request, address, grant
//             RspValid1/RspReady1     port 1 response handshake
//             RspData                 shared response data
//             RomCEB/RomA/RomQ        ROM macro interface (CEB active low)
//  Revision : 1.0  initial release
// ============================================================================
module rom128x32_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  output logic              Gnt0,
  output logic              RspValid0,
  input  logic              RspReady0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  output logic              Gnt1,
  output logic              RspValid1,
  input  logic              RspReady1,
  output logic [DATA_W-1:0] RspData,
  output logic              RomCEB,
  output logic [ADDR_W-1:0] RomA,
  input  logic [DATA_W-1:0] RomQ
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic w_accept;
  logic w_grant_ok;
  logic w_winner;
  logic w_grant;

  // Grant decision. Held in reset so no ROM access or grant leaks out while
  // resetn is low. Only the owner's ready can accept the held response.
  always_comb begin
    w_accept   = (state_q == ST_RESP) && (owner_q ? RspReady1 : RspReady0);
    w_grant_ok = resetn && ((state_q == ST_IDLE) || w_accept);
    w_winner   = (Req0 && Req1) ? prio_q : Req1;
    w_grant    = w_grant_ok && (Req0 || Req1);
  end

  assign Gnt0      = w_grant && !w_winner;
  assign Gnt1      = w_grant &&  w_winner;
  assign RomCEB    = !w_grant;
  assign RomA      = w_grant ? (w_winner ? Addr1 : Addr0) : '0;
  assign RspValid0 = rsp_valid_q && !owner_q;
  assign RspValid1 = rsp_valid_q &&  owner_q;
  assign RspData   = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // ROM output is valid exactly one cycle after the enabled edge.
        rsp_data_d  = RomQ;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Accept overlaps the next grant to sustain one read per 2 cycles.
        if (w_accept) begin
          rsp_valid_d = 1'b0;
          state_d     = w_grant ? ST_ACCESS : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_grant) begin
      owner_d = w_winner;
      prio_d  = !w_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire
